mem_arb: RTL and testbench

Two-master, one-slave arbiter for the multi-cycle core's single memory port. It shares the port between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). It grants one requester at a time, alternates fairly under contention, registers the outgoing request and the returned data, and aborts a stalled access with an error after a bounded wait. It sits between the core stages and the bus/SRAM interface.

---
 rtl/mem_arb.sv | 173 +++++++++++++++++
 tb/tb_mem_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// ============================================================================
// Module   : mem_arb
// Purpose  : Two-master (fetch / load-store) arbiter for one memory port,
//            with fair alternation, registered slave request and timeout abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_be,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              err,
  output logic              busy,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int   c_CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic c_GNT_IF = 1'b0;
  localparam logic c_GNT_LS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_LS = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_gnt;
  logic                r_gnt_ls;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [3:0]          r_m_be;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_next;
  logic                w_grant_if;
  logic                w_grant_ls;
  logic                w_done;
  logic                w_timeout;
  logic                w_resp;

  assign w_cnt_next = r_cnt + c_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_ls   = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Under contention the master that did not win last time goes first.
        if (if_req && (!ls_req || (r_last_gnt == c_GNT_LS))) begin
          w_grant_if   = 1'b1;
          w_state_next = S_BUSY_IF;
        end else if (ls_req) begin
          w_grant_ls   = 1'b1;
          w_state_next = S_BUSY_LS;
        end
      end
      S_BUSY_IF, S_BUSY_LS: begin
        if (m_ack) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end else if (w_cnt_next == c_CNT_W'(TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_gnt <= c_GNT_LS;
      r_gnt_ls   <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_be     <= 4'h0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_grant_if) begin
        r_last_gnt <= c_GNT_IF;
        r_gnt_ls   <= 1'b0;
        r_m_req    <= 1'b1;
        r_m_we     <= 1'b0;
        r_m_addr   <= if_addr;
        r_m_wdata  <= '0;
        r_m_be     <= 4'hF;
        r_cnt      <= '0;
      end else if (w_grant_ls) begin
        r_last_gnt <= c_GNT_LS;
        r_gnt_ls   <= 1'b1;
        r_m_req    <= 1'b1;
        r_m_we     <= ls_we;
        r_m_addr   <= ls_addr;
        r_m_wdata  <= ls_wdata;
        r_m_be     <= ls_be;
        r_cnt      <= '0;
      end else if (w_done) begin
        r_m_req <= 1'b0;
        r_rdata <= m_rdata;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_m_req <= 1'b0;
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (r_m_req) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign w_resp   = (r_state == S_RESP);
  assign if_ack   = w_resp & ~r_gnt_ls;
  assign ls_ack   = w_resp &  r_gnt_ls;
  assign if_rdata = if_ack ? r_rdata : '0;
  assign ls_rdata = ls_ack ? r_rdata : '0;
  assign err      = w_resp & r_err;
  assign busy     = (r_state != S_IDLE);
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_be     = r_m_be;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
// Module   : tb_mem_arb
// Purpose  : Self-checking bench for mem_arb: vector table plus corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = 4'h0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        err;
  logic        busy;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .err(err), .busy(busy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  typedef struct {
    logic        if_req;
    logic        ls_req;
    logic        we;
    logic [31:0] if_addr;
    logic [31:0] ls_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] sdata;
    logic        exp_ls;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    int          exp_nreq;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    m_ack  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {m_req, m_we, m_be, if_ack, ls_ack, err, busy}, '0);
    chk("reset_dat", {m_addr, m_wdata, if_rdata, ls_rdata}, '0);
    rstn = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    int  nreq;
    bit  seen;
    cyc  = 0;
    nreq = 0;
    seen = 1'b0;
    @(negedge clk);
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    ls_req   = v.ls_req;
    ls_we    = v.we;
    ls_addr  = v.ls_addr;
    ls_wdata = v.wdata;
    ls_be    = v.be;
    m_rdata  = v.sdata;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      m_ack = 1'b0;
      if (m_req) begin
        nreq++;
        chk($sformatf("v%0d_m_fields", idx), {m_we, m_be, m_addr, m_wdata},
            {v.exp_we, v.exp_be, v.exp_addr, v.exp_wdata});
        if (nreq == v.waits + 1) m_ack = 1'b1;
      end
      if (if_ack || ls_ack) begin
        seen = 1'b1;
        chk($sformatf("v%0d_ack_cycle", idx), cyc, v.exp_cyc);
        chk($sformatf("v%0d_ack_who", idx), {if_ack, ls_ack}, {~v.exp_ls, v.exp_ls});
        chk($sformatf("v%0d_rdata", idx), v.exp_ls ? ls_rdata : if_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), err, v.exp_err);
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL v%0d_no_ack: got none within %0d cycles expected ack", idx, cyc);
      if_req = 1'b0;
      ls_req = 1'b0;
    end
    chk($sformatf("v%0d_mreq_cycles", idx), nreq, v.exp_nreq);
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", idx), {busy, if_ack, ls_ack, err}, 4'b0);
  endtask

  // Zero-wait slave that echoes the address as read data.
  task automatic auto_slave_cycle();
    m_ack   = m_req;
    m_rdata = m_addr;
  endtask

  initial begin
    int          nack;
    int          ack_at[8];
    logic        ack_ls[8];
    logic [31:0] ack_dat[8];
    int          cnt;

    //            ifr ls  we  if_addr       ls_addr       wdata          be     w    sdata
    //            ex_ls ex_we ex_addr ex_wdata ex_be nreq cyc rdata err
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0999, 32'hBADB_AD00, 4'h0, 0, 32'hDEAD_BEEF,
                1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 2, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0555, 32'h0000_2004, 32'h1234_5678, 4'b0011, 3, 32'hA5A5_A5A5,
                1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 4, 5, 32'hA5A5_A5A5, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3000, 32'h0000_0077, 4'hF, 1, 32'hCAFE_F00D,
                1'b1, 1'b0, 32'h0000_3000, 32'h0000_0077, 4'hF, 2, 3, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0055, 4'h0, 100, 32'hFFFF_FFFF,
                1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 15, 16, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h0, 4'h0, 0, 32'h1111_2222,
                1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 1, 2, 32'h1111_2222, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_040C, 32'h0, 4'hC, 2, 32'h89AB_CDEF,
                1'b1, 1'b0, 32'h0000_040C, 32'h0, 4'hC, 3, 4, 32'h89AB_CDEF, 1'b0};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Continuous contention from reset: IF, LS, IF, LS, 3 cycles apart.
    do_reset();
    nack = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_addr = 32'h80; ls_we = 1'b0; ls_be = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      auto_slave_cycle();
      if (if_ack && ls_ack) chk("contend_both_acks", {if_ack, ls_ack}, 2'b00);
      if ((if_ack || ls_ack) && nack < 8) begin
        ack_at[nack]  = c;
        ack_ls[nack]  = ls_ack;
        ack_dat[nack] = ls_ack ? ls_rdata : if_rdata;
        nack++;
      end
      if (c == 12) begin
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    m_ack = 1'b0;
    chk("contend_count", nack, 4);
    for (int k = 0; k < 4 && k < nack; k++) begin
      chk($sformatf("contend_at%0d", k), ack_at[k], 2 + 3 * k);
      chk($sformatf("contend_who%0d", k), ack_ls[k], k % 2);
      chk($sformatf("contend_dat%0d", k), ack_dat[k], (k % 2) ? 32'h80 : 32'h40);
    end
    @(negedge clk);
    chk("contend_idle", busy, 1'b0);

    // Reset while BUSY_LS with m_req high.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h500; ls_wdata = 32'hFACE; ls_be = 4'h5;
    m_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid_mreq", m_req, 1'b1);
    rstn = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {m_req, m_we, m_be, if_ack, ls_ack, err, busy}, '0);
    chk("rst_mid_dat", {m_addr, m_wdata, if_rdata, ls_rdata}, '0);
    rstn = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (ls_ack || if_ack) cnt++;
    end
    chk("rst_mid_no_ack", cnt, 0);
    if_req = 1'b1; if_addr = 32'h44;
    ls_req = 1'b1; ls_addr = 32'h88;
    nack = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      auto_slave_cycle();
      if ((if_ack || ls_ack) && nack == 0) begin
        nack = 1;
        chk("rst_then_if_first", {if_ack, ls_ack}, 2'b10);
        chk("rst_then_cycle", c, 2);
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    if (nack == 0) chk("rst_then_ack_seen", 1'b0, 1'b1);
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      auto_slave_cycle();
    end
    m_ack = 1'b0;
    chk("rst_then_idle", busy, 1'b0);

    // ls_req dropped and address changed right after grant.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600; ls_be = 4'hF;
    m_rdata = 32'h600D_F00D;
    @(negedge clk);
    chk("drop_mreq", m_req, 1'b1);
    ls_req  = 1'b0;
    ls_addr = 32'h700;
    @(negedge clk);
    chk("drop_addr_held", m_addr, 32'h600);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("drop_ack", {if_ack, ls_ack}, 2'b01);
    chk("drop_rdata", ls_rdata, 32'h600D_F00D);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ls_ack || if_ack) cnt++;
    end
    chk("drop_single_ack", cnt, 0);

    // m_ack while idle must be ignored.
    m_ack = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || m_req || if_ack || ls_ack || err) cnt++;
    end
    m_ack = 1'b0;
    chk("idle_mack_ignored", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
